reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Architectural register file plus rename table, directly downstream of the reorder buffer's commit port and upstream of the dispatcher's operand fetch.
- Holds committed register values and the ROB tag of the latest in-flight producer of each register.
- Dispatcher reads operands as (data, tag) pairs. A tag equal to TAG_FREE means the data is valid.
- Keeps per-branch snapshots of the rename table and restores one on a mispredict.

Parameters:
DATA_W, 32, data width
NAME_W, 5, register name width (2^NAME_W registers)
TAG_W, 5, ROB tag width; low TAG_W-1 bits index the ROB
TAG_FREE, 5'b10000, "no pending producer" tag value
BR_SLOTS, 4, number of branch snapshot slots (slot index is 2 bits)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
enCom  in  1  commit valid from ROB
ComTag  in  TAG_W  ROB tag of committing entry
ComData  in  DATA_W  committed value
ComName  in  NAME_W  destination register
ReadNameO  in  NAME_W  operand 1 register
ReadNameT  in  NAME_W  operand 2 register
ReadDataO  out  DATA_W  operand 1 value (valid when ReadTagO==TAG_FREE)
ReadTagO  out  TAG_W  operand 1 pending tag
ReadDataT  out  DATA_W  operand 2 value
ReadTagT  out  TAG_W  operand 2 pending tag
enRename  in  1  dispatcher allocates a destination
RenameName  in  NAME_W  destination register
RenameTag  in  TAG_W  tag from ROB freeTag
bSaveEn  in  1  snapshot rename table into slot bSaveNum
bSaveNum  in  2  slot index
bMissEn  in  1  mispredict: restore slot bMissNum
bMissNum  in  2  slot index
bFreeEn  in  1  branch resolved correctly: release slot bFreeNum
bFreeNum  in  2  slot index

Behaviour:
- Reset (async): all data = 0, all tags = TAG_FREE, all snapshot slots invalid with tags TAG_FREE.
- Register 0 hardwired:
  - reads return data 0, tag TAG_FREE;
  - rename and commit to name 0 are ignored.
- Reads are combinational from current state, in priority order:
  - if enCom and tag[name]==ComTag: output data=ComData, tag=TAG_FREE (commit bypass);
  - else output data[name], tag[name].
  - A same-cycle rename is not visible to reads until the next cycle.
- Commit (posedge, enCom, ComName!=0):
  - data[ComName] <= ComData unconditionally.
  - tag[ComName] <= TAG_FREE only if tag[ComName]==ComTag and no same-cycle rename of ComName.
  - In every valid snapshot slot, any entry whose tag equals ComTag is set to TAG_FREE.
- Rename (posedge, enRename, RenameName!=0): tag[RenameName] <= RenameTag. Rename beats commit clearing on the same register.
- Save (posedge, bSaveEn):
  - slot[bSaveNum] <= rename table as updated this cycle, i.e. including a same-cycle rename and commit clear;
  - slot marked valid;
  - saving into an already-valid slot overwrites it.
- Restore (posedge, bMissEn):
  - live tag table <= slot[bMissNum] with the same-cycle commit clear applied;
  - same-cycle rename and save are dropped;
  - all slots invalidated;
  - data array untouched;
  - bMissEn on an invalid slot restores its contents anyway (dispatcher guarantees validity).
- Free (posedge, bFreeEn): slot[bFreeNum] invalid.
  - Free and save on the same slot in the same cycle: save wins.
  - bMissEn and bFreeEn in the same cycle: restore wins.
- Reset asserted mid-operation clears everything immediately regardless of pending inputs.
- No handshake stalls; all inputs are accepted every cycle.

Test Plan:
- Reset, read x5 -> data 0, tag TAG_FREE; read x0 after rename(x0, tag 3) -> tag TAG_FREE.
- rename(x5, tag 2); next cycle read x5 -> tag 2. Commit(tag 2, x5, 0xDEAD) -> same-cycle read returns 0xDEAD / TAG_FREE. Next cycle tag[x5]=TAG_FREE, data 0xDEAD.
- rename(x5, 2); then rename(x5, 7) and commit(tag 2, x5, 0x11) in the same cycle -> next cycle tag[x5]=7, data[x5]=0x11.
- rename(x3, 4); save slot 1; rename(x3, 6); commit(tag 4, x3, 0x55); bMissEn slot 1 -> tag[x3]=TAG_FREE, data 0x55.
- rename(x8, 9); save slot 2; rename(x8, 10); bMissEn slot 2 together with rename(x9, 11) -> tag[x8]=9, tag[x9]=TAG_FREE, slots invalid.
- Assert rst mid-sequence with pending tags -> all tags TAG_FREE, data 0 without a clock edge.

Source files
------------

// File: rtl/reg_rename_file_if.sv
// Operand-fetch / commit / rename / branch-snapshot bus of the architectural
// register file and rename table.
interface reg_rename_file_if #(
   parameter int DATA_W = 32,
   parameter int NAME_W = 5,
   parameter int TAG_W  = 5
);

   // commit port from the reorder buffer
   logic              enCom;
   logic [TAG_W-1:0]  ComTag;
   logic [DATA_W-1:0] ComData;
   logic [NAME_W-1:0] ComName;

   // operand read ports
   logic [NAME_W-1:0] ReadNameO;
   logic [NAME_W-1:0] ReadNameT;
   logic [DATA_W-1:0] ReadDataO;
   logic [TAG_W-1:0]  ReadTagO;
   logic [DATA_W-1:0] ReadDataT;
   logic [TAG_W-1:0]  ReadTagT;

   // destination rename from the dispatcher
   logic              enRename;
   logic [NAME_W-1:0] RenameName;
   logic [TAG_W-1:0]  RenameTag;

   // branch snapshot control
   logic              bSaveEn;
   logic [1:0]        bSaveNum;
   logic              bMissEn;
   logic [1:0]        bMissNum;
   logic              bFreeEn;
   logic [1:0]        bFreeNum;

   modport master (
      output enCom, ComTag, ComData, ComName,
      output ReadNameO, ReadNameT,
      input  ReadDataO, ReadTagO, ReadDataT, ReadTagT,
      output enRename, RenameName, RenameTag,
      output bSaveEn, bSaveNum, bMissEn, bMissNum, bFreeEn, bFreeNum
   );

   modport slave (
      input  enCom, ComTag, ComData, ComName,
      input  ReadNameO, ReadNameT,
      output ReadDataO, ReadTagO, ReadDataT, ReadTagT,
      input  enRename, RenameName, RenameTag,
      input  bSaveEn, bSaveNum, bMissEn, bMissNum, bFreeEn, bFreeNum
   );

endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with rename table (latest in-flight ROB tag per
// register) and per-branch rename-table snapshots restored on a mispredict.
module reg_rename_file #(
   parameter int              DATA_W   = 32,
   parameter int              NAME_W   = 5,
   parameter int              TAG_W    = 5,
   parameter logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}},
   parameter int              BR_SLOTS = 4
) (
   input logic              clk,
   input logic              rst,
   reg_rename_file_if.slave bus
);

   localparam int NREG   = 2 ** NAME_W;
   localparam int SLOT_W = (BR_SLOTS > 1) ? $clog2(BR_SLOTS) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } rd_t;

   logic [DATA_W-1:0] data_q       [NREG];
   logic [TAG_W-1:0]  tag_q        [NREG];
   logic [TAG_W-1:0]  tag_upd      [NREG];
   logic [TAG_W-1:0]  tag_restore  [NREG];
   logic [TAG_W-1:0]  tag_nxt      [NREG];
   logic [TAG_W-1:0]  slot_tag_q   [BR_SLOTS][NREG];
   logic [TAG_W-1:0]  slot_tag_nxt [BR_SLOTS][NREG];
   logic              slot_vld_q   [BR_SLOTS];
   logic              slot_vld_nxt [BR_SLOTS];

   logic com_en;
   logic ren_en;
   logic com_hit;
   rd_t  rd_o;
   rd_t  rd_t_port;

   assign com_en  = bus.enCom && (bus.ComName != '0);
   assign ren_en  = bus.enRename && (bus.RenameName != '0);
   assign com_hit = com_en && (tag_q[bus.ComName] == bus.ComTag);

   // Operand read: x0 is constant, otherwise a matching commit bypasses the array.
   function automatic rd_t read_port(input logic [NAME_W-1:0] name);
      rd_t r;
      if (name == '0) begin
         r.data = '0;
         r.tag  = TAG_FREE;
      end else if (bus.enCom && (tag_q[name] == bus.ComTag)) begin
         r.data = bus.ComData;
         r.tag  = TAG_FREE;
      end else begin
         r.data = data_q[name];
         r.tag  = tag_q[name];
      end
      return r;
   endfunction

   always_comb begin
      rd_o          = read_port(bus.ReadNameO);
      rd_t_port     = read_port(bus.ReadNameT);
      bus.ReadDataO = rd_o.data;
      bus.ReadTagO  = rd_o.tag;
      bus.ReadDataT = rd_t_port.data;
      bus.ReadTagT  = rd_t_port.tag;
   end

   // Live table after this cycle's commit clear and rename; rename wins.
   always_comb begin
      for (int unsigned i = 0; i < NREG; i++) begin
         tag_upd[i] = tag_q[i];
      end
      if (com_hit) begin
         tag_upd[bus.ComName] = TAG_FREE;
      end
      if (ren_en) begin
         tag_upd[bus.RenameName] = bus.RenameTag;
      end
   end

   // Snapshot contents with this cycle's commit applied; slot validity is ignored.
   always_comb begin
      for (int unsigned i = 0; i < NREG; i++) begin
         if (com_en && (slot_tag_q[bus.bMissNum][i] == bus.ComTag)) begin
            tag_restore[i] = TAG_FREE;
         end else begin
            tag_restore[i] = slot_tag_q[bus.bMissNum][i];
         end
      end
      tag_restore[0] = TAG_FREE;
   end

   always_comb begin
      for (int unsigned i = 0; i < NREG; i++) begin
         tag_nxt[i] = bus.bMissEn ? tag_restore[i] : tag_upd[i];
      end
   end

   // Priority per slot: restore invalidates all, then save, then free.
   always_comb begin
      for (int unsigned s = 0; s < BR_SLOTS; s++) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (slot_vld_q[s] && com_en && (slot_tag_q[s][i] == bus.ComTag)) begin
               slot_tag_nxt[s][i] = TAG_FREE;
            end else begin
               slot_tag_nxt[s][i] = slot_tag_q[s][i];
            end
         end
         slot_vld_nxt[s] = slot_vld_q[s];
         if (bus.bMissEn) begin
            slot_vld_nxt[s] = 1'b0;
         end else if (bus.bSaveEn && (bus.bSaveNum == SLOT_W'(s))) begin
            for (int unsigned i = 0; i < NREG; i++) begin
               slot_tag_nxt[s][i] = tag_upd[i];
            end
            slot_vld_nxt[s] = 1'b1;
         end else if (bus.bFreeEn && (bus.bFreeNum == SLOT_W'(s))) begin
            slot_vld_nxt[s] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= TAG_FREE;
         end
         for (int unsigned s = 0; s < BR_SLOTS; s++) begin
            slot_vld_q[s] <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
               slot_tag_q[s][i] <= TAG_FREE;
            end
         end
      end else begin
         if (com_en) begin
            data_q[bus.ComName] <= bus.ComData;
         end
         for (int unsigned i = 0; i < NREG; i++) begin
            tag_q[i] <= tag_nxt[i];
         end
         for (int unsigned s = 0; s < BR_SLOTS; s++) begin
            slot_vld_q[s] <= slot_vld_nxt[s];
            for (int unsigned i = 0; i < NREG; i++) begin
               slot_tag_q[s][i] <= slot_tag_nxt[s][i];
            end
         end
      end
   end

   a_x0_tag_free : assert property (@(posedge clk) disable iff (rst) tag_q[0] == TAG_FREE);
   a_x0_data_zero : assert property (@(posedge clk) disable iff (rst) data_q[0] == '0);

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed-vector bench for reg_rename_file: rename, commit bypass, branch
// snapshot save/restore/free and asynchronous reset.
module tb_reg_rename_file;

   localparam logic [4:0] FREE = 5'b10000;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   reg_rename_file_if #(.DATA_W(32), .NAME_W(5), .TAG_W(5)) bus ();

   reg_rename_file #(
      .DATA_W  (32),
      .NAME_W  (5),
      .TAG_W   (5),
      .TAG_FREE(5'b10000),
      .BR_SLOTS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      bus.enCom      = 1'b0;
      bus.ComTag     = '0;
      bus.ComData    = '0;
      bus.ComName    = '0;
      bus.enRename   = 1'b0;
      bus.RenameName = '0;
      bus.RenameTag  = '0;
      bus.bSaveEn    = 1'b0;
      bus.bSaveNum   = '0;
      bus.bMissEn    = 1'b0;
      bus.bMissNum   = '0;
      bus.bFreeEn    = 1'b0;
      bus.bFreeNum   = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic rd(input logic [4:0] no, input logic [4:0] nt);
      bus.ReadNameO = no;
      bus.ReadNameT = nt;
      #1;
   endtask

   task automatic rename(input logic [4:0] n, input logic [4:0] t);
      bus.enRename   = 1'b1;
      bus.RenameName = n;
      bus.RenameTag  = t;
   endtask

   task automatic commit(input logic [4:0] t, input logic [4:0] n, input logic [31:0] d);
      bus.enCom   = 1'b1;
      bus.ComTag  = t;
      bus.ComName = n;
      bus.ComData = d;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b0;
      clear_in();
      bus.ReadNameO = '0;
      bus.ReadNameT = '0;
      #2 rst = 1'b1;
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      // reset state and x0
      rd(5'd5, 5'd5);
      check("rst_data_x5", bus.ReadDataO, 32'h0);
      check("rst_tag_x5", bus.ReadTagO, FREE);
      rename(5'd0, 5'd3);
      tick();
      rd(5'd0, 5'd0);
      check("x0_tag", bus.ReadTagT, FREE);
      check("x0_data", bus.ReadDataT, 32'h0);

      // rename then commit with bypass
      rename(5'd5, 5'd2);
      tick();
      rd(5'd5, 5'd5);
      check("ren_tag_x5", bus.ReadTagO, 5'd2);
      commit(5'd2, 5'd5, 32'hDEAD);
      #1;
      check("byp_data_x5", bus.ReadDataO, 32'hDEAD);
      check("byp_tag_x5", bus.ReadTagT, FREE);
      tick();
      rd(5'd5, 5'd5);
      check("com_tag_x5", bus.ReadTagO, FREE);
      check("com_data_x5", bus.ReadDataO, 32'hDEAD);

      // same-cycle rename beats commit clear
      rename(5'd5, 5'd2);
      tick();
      rename(5'd5, 5'd7);
      commit(5'd2, 5'd5, 32'h11);
      #1;
      check("byp2_data_x5", bus.ReadDataO, 32'h11);
      tick();
      rd(5'd5, 5'd5);
      check("renwin_tag_x5", bus.ReadTagO, 5'd7);
      check("renwin_data_x5", bus.ReadDataO, 32'h11);

      // commit clears entry inside a valid snapshot before restore
      rename(5'd3, 5'd4);
      tick();
      bus.bSaveEn  = 1'b1;
      bus.bSaveNum = 2'd1;
      tick();
      rename(5'd3, 5'd6);
      tick();
      commit(5'd4, 5'd3, 32'h55);
      tick();
      rd(5'd3, 5'd3);
      check("pre_miss_tag_x3", bus.ReadTagO, 5'd6);
      bus.bMissEn  = 1'b1;
      bus.bMissNum = 2'd1;
      tick();
      rd(5'd3, 5'd5);
      check("miss1_tag_x3", bus.ReadTagO, FREE);
      check("miss1_data_x3", bus.ReadDataO, 32'h55);
      check("miss1_tag_x5", bus.ReadTagT, 5'd7);

      // restore drops same-cycle rename and invalidates slots
      rename(5'd8, 5'd9);
      tick();
      bus.bSaveEn  = 1'b1;
      bus.bSaveNum = 2'd2;
      tick();
      rename(5'd8, 5'd10);
      tick();
      bus.bMissEn  = 1'b1;
      bus.bMissNum = 2'd2;
      rename(5'd9, 5'd11);
      tick();
      rd(5'd8, 5'd9);
      check("miss2_tag_x8", bus.ReadTagO, 5'd9);
      check("miss2_tag_x9", bus.ReadTagT, FREE);
      // slot 2 is now invalid, so this commit must not clear its copy of x8
      commit(5'd9, 5'd8, 32'h99);
      tick();
      rd(5'd8, 5'd8);
      check("com_tag_x8", bus.ReadTagO, FREE);
      bus.bMissEn  = 1'b1;
      bus.bMissNum = 2'd2;
      tick();
      rd(5'd8, 5'd8);
      check("inval_tag_x8", bus.ReadTagO, 5'd9);
      check("inval_data_x8", bus.ReadDataO, 32'h99);

      // save captures same-cycle rename
      rename(5'd10, 5'd12);
      bus.bSaveEn  = 1'b1;
      bus.bSaveNum = 2'd0;
      tick();
      rename(5'd10, 5'd13);
      tick();
      bus.bMissEn  = 1'b1;
      bus.bMissNum = 2'd0;
      tick();
      rd(5'd10, 5'd10);
      check("save_ren_x10", bus.ReadTagO, 5'd12);

      // freed slot no longer receives commit clears
      rename(5'd11, 5'd14);
      bus.bSaveEn  = 1'b1;
      bus.bSaveNum = 2'd3;
      tick();
      bus.bFreeEn  = 1'b1;
      bus.bFreeNum = 2'd3;
      tick();
      commit(5'd14, 5'd11, 32'h77);
      tick();
      bus.bMissEn  = 1'b1;
      bus.bMissNum = 2'd3;
      tick();
      rd(5'd11, 5'd11);
      check("free_tag_x11", bus.ReadTagO, 5'd14);

      // restore with same-cycle commit clear applied
      rename(5'd12, 5'd15);
      bus.bSaveEn  = 1'b1;
      bus.bSaveNum = 2'd0;
      tick();
      bus.bMissEn  = 1'b1;
      bus.bMissNum = 2'd0;
      commit(5'd15, 5'd12, 32'hABC);
      tick();
      rd(5'd12, 5'd12);
      check("miss_com_tag_x12", bus.ReadTagO, FREE);
      check("miss_com_data_x12", bus.ReadDataO, 32'hABC);

      // asynchronous reset mid-operation
      rename(5'd4, 5'd5);
      tick();
      rd(5'd4, 5'd3);
      check("pre_rst_tag_x4", bus.ReadTagO, 5'd5);
      rst = 1'b1;
      #1;
      check("arst_tag_x4", bus.ReadTagO, FREE);
      check("arst_data_x3", bus.ReadDataT, 32'h0);
      #1 rst = 1'b0;
      rd(5'd11, 5'd8);
      check("arst_tag_x11", bus.ReadTagO, FREE);
      check("arst_data_x8", bus.ReadDataT, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
